// File: rtl/dct_beffft_reod.sv
// Input reorder stage ahead of the FFT core of the FFT-based DCT.
// Buffers one frame, emits evens ascending then odds descending.
module dct_beffft_reod #(
  parameter int wDataInOut = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sink_valid,
  output logic                  sink_ready,
  input  logic [1:0]            sink_error,
  input  logic                  sink_sop,
  input  logic                  sink_eop,
  input  logic [wDataInOut-1:0] sink_real,
  input  logic [wDataInOut-1:0] sink_imag,
  input  logic [11:0]           fftpts_in,
  output logic                  source_valid,
  input  logic                  source_ready,
  output logic [1:0]            source_error,
  output logic                  source_sop,
  output logic                  source_eop,
  output logic [wDataInOut-1:0] source_real,
  output logic [wDataInOut-1:0] source_imag,
  output logic [11:0]           fftpts_out
);

  localparam int W = wDataInOut;

  typedef enum logic [1:0] {
    S_IDLE, S_WR, S_WAIT, S_RD
  } state_t;

  state_t       r_state;
  logic [11:0]  r_cnt;
  logic [11:0]  r_n;
  logic [1:0]   r_err;
  logic         r_mis;
  logic [2*W-1:0] r_mem0 [0:1023];
  logic [2*W-1:0] r_mem1 [0:1023];
  logic [2*W-1:0] r_q0;
  logic [2*W-1:0] r_q1;
  logic         r_v1;
  logic         r_sop1;
  logic         r_eop1;
  logic         r_sel1;

  logic         w_acc;
  logic         w_pow;
  logic [11:0]  w_nin;
  logic         w_we;
  logic [11:0]  w_widx;
  logic [2*W-1:0] w_wd;
  logic         w_last;
  logic [11:0]  w_half;
  logic         w_rsel;
  logic [11:0]  w_rev;
  logic [9:0]   w_raddr;
  logic         w_re;
  logic         w_unused;

  assign w_acc = sink_valid & sink_ready;
  // Anything but a power of two in 32..2048 runs as 2048.
  assign w_pow = (fftpts_in >= 12'd32) &&
                 ((fftpts_in & (fftpts_in - 12'd1)) == 12'd0);
  assign w_nin = w_pow ? fftpts_in : 12'd2048;

  assign w_we = w_acc &
                (((r_state == S_IDLE) & sink_sop) |
                 (r_state == S_WR));
  assign w_widx = (r_state == S_IDLE) ? 12'd0 : r_cnt;
  assign w_wd   = {sink_real, sink_imag};

  assign w_last  = (r_cnt == r_n - 12'd1);
  assign w_half  = {1'b0, r_n[11:1]};
  assign w_rsel  = (r_cnt >= w_half);
  assign w_rev   = r_n - 12'd1 - r_cnt;
  assign w_raddr = w_rsel ? w_rev[9:0] : r_cnt[9:0];
  assign w_re    = (r_state == S_RD) && (r_cnt < r_n);

  assign w_unused = ^{w_widx[11], w_rev[11:10]};

  always_ff @(posedge clk) begin
    if (w_we & ~w_widx[0])
      r_mem0[w_widx[10:1]] <= w_wd;
    if (w_we & w_widx[0])
      r_mem1[w_widx[10:1]] <= w_wd;
    if (w_re) begin
      r_q0 <= r_mem0[w_raddr];
      r_q1 <= r_mem1[w_raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      sink_ready   <= 1'b0;
      r_cnt        <= '0;
      r_n          <= '0;
      r_err        <= '0;
      r_mis        <= 1'b0;
      r_v1         <= 1'b0;
      r_sop1       <= 1'b0;
      r_eop1       <= 1'b0;
      r_sel1       <= 1'b0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_error <= '0;
      source_real  <= '0;
      source_imag  <= '0;
      fftpts_out   <= '0;
    end else begin
      r_v1         <= w_re;
      r_sop1       <= w_re & (r_cnt == 12'd0);
      r_eop1       <= w_re & w_last;
      r_sel1       <= w_rsel;
      source_valid <= r_v1;
      source_sop   <= r_sop1;
      source_eop   <= r_eop1;
      if (r_v1) begin
        source_real <= r_sel1 ? r_q1[2*W-1:W] : r_q0[2*W-1:W];
        source_imag <= r_sel1 ? r_q1[W-1:0]   : r_q0[W-1:0];
      end
      unique case (r_state)
        S_IDLE: begin
          sink_ready <= 1'b1;
          if (w_acc & sink_sop) begin
            r_n        <= w_nin;
            fftpts_out <= w_nin;
            r_err      <= sink_error;
            r_cnt      <= 12'd1;
            r_mis      <= sink_eop;
            if (sink_eop) begin
              r_state    <= S_WAIT;
              sink_ready <= 1'b0;
            end else begin
              r_state <= S_WR;
            end
          end
        end
        S_WR: begin
          if (w_acc) begin
            r_cnt <= r_cnt + 12'd1;
            r_err <= r_err | sink_error;
            if (sink_eop | w_last) begin
              r_state    <= S_WAIT;
              sink_ready <= 1'b0;
              r_mis      <= sink_eop ^ w_last;
            end
          end
        end
        S_WAIT: begin
          if (source_ready) begin
            r_state      <= S_RD;
            r_cnt        <= '0;
            source_error <= r_err | {1'b0, r_mis};
          end
        end
        S_RD: begin
          if (w_re)
            r_cnt <= r_cnt + 12'd1;
          if (source_eop) begin
            r_state    <= S_IDLE;
            sink_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_beffft_reod.sv
// Scoreboard bench for dct_beffft_reod: random frames, queue model,
// decoupled output monitor.
module tb_dct_beffft_reod;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sink_valid;
  logic        sink_ready;
  logic [1:0]  sink_error;
  logic        sink_sop;
  logic        sink_eop;
  logic [15:0] sink_real;
  logic [15:0] sink_imag;
  logic [11:0] fftpts_in;
  logic        source_valid;
  logic        source_ready;
  logic [1:0]  source_error;
  logic        source_sop;
  logic        source_eop;
  logic [15:0] source_real;
  logic [15:0] source_imag;
  logic [11:0] fftpts_out;

  dct_beffft_reod #(.wDataInOut(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .sink_valid(sink_valid), .sink_ready(sink_ready),
    .sink_error(sink_error), .sink_sop(sink_sop),
    .sink_eop(sink_eop), .sink_real(sink_real),
    .sink_imag(sink_imag), .fftpts_in(fftpts_in),
    .source_valid(source_valid), .source_ready(source_ready),
    .source_error(source_error), .source_sop(source_sop),
    .source_eop(source_eop), .source_real(source_real),
    .source_imag(source_imag), .fftpts_out(fftpts_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    bit          known;
    logic        sop;
    logic        eop;
    logic [1:0]  err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] hist [0:2047];
  bit          hknown [0:2047];
  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  bit          in_frame = 0;
  bit          lat_chk = 0;
  time         t_ref = 0;

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    exp_t x;
    if (!rst_n) begin
      in_frame = 0;
      lat_chk  = 0;
    end else if (source_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        x = sb.pop_front();
        chk("sop", source_sop, x.sop);
        chk("eop", source_eop, x.eop);
        chk("error", source_error, x.err);
        if (x.known)
          chk("data", {source_real, source_imag}, x.d);
      end
      chk("sink_ready_in_readout", sink_ready, 0);
      if (source_sop) begin
        if (lat_chk) chk("sop_latency", $time - t_ref, 30);
        lat_chk  = 0;
        in_frame = 1;
      end
      if (source_eop) in_frame = 0;
      pops++;
    end else if (in_frame) begin
      chk("valid_gap", 0, 1);
      in_frame = 0;
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic put(input logic [15:0] re, input logic [15:0] im,
                     input logic sop, input logic eop,
                     input logic [1:0] err, input logic [11:0] nin,
                     input bit last);
    int t = 0;
    sink_valid = 1'b1;
    sink_real  = re;
    sink_imag  = im;
    sink_sop   = sop;
    sink_eop   = eop;
    sink_error = err;
    fftpts_in  = nin;
    while (!sink_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) chk("sink_ready_timeout", 0, 1);
    @(negedge clk);
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    sink_error = 2'b00;
    if (last && source_ready) begin
      t_ref   = $time;
      lat_chk = 1;
    end
  endtask

  task automatic push_exp(input int idx, input logic [1:0] e,
                          input logic sop, input logic eop);
    exp_t x;
    x.d     = hist[idx];
    x.known = hknown[idx];
    x.sop   = sop;
    x.eop   = eop;
    x.err   = e;
    sb.push_back(x);
  endtask

  task automatic send_frame(input logic [11:0] nin, input int nsamp,
                            input bit eop_en, input int gap,
                            input bit ramp, input logic [1:0] err);
    int          neff = 2048;
    bit          mis;
    logic [1:0]  e;
    logic [15:0] re;
    logic [15:0] im;
    for (int p = 32; p <= 2048; p = p * 2)
      if (int'(nin) == p) neff = p;
    for (int n = 0; n < nsamp; n++) begin
      re = ramp ? 16'(n) : 16'($urandom);
      im = ramp ? 16'(-n) : 16'($urandom);
      while (gap > 0 && int'($urandom_range(99)) < gap)
        @(negedge clk);
      put(re, im, n == 0, eop_en && n == nsamp - 1,
          (n == 0) ? err : 2'b00, nin, n == nsamp - 1);
      hist[n]   = {re, im};
      hknown[n] = 1;
    end
    mis = eop_en ? (nsamp != neff) : 1'b1;
    e   = err | {1'b0, mis};
    for (int i = 0; i < neff; i += 2)
      push_exp(i, e, i == 0, 1'b0);
    for (int i = neff - 1; i > 0; i -= 2)
      push_exp(i, e, 1'b0, i == 1);
    chk("fftpts_out", fftpts_out, neff);
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() > 0 || in_frame) && t < 10000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 10000) chk("drain_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t;
    for (int i = 0; i < 2048; i++) hknown[i] = 0;
    rst_n = 1'b0;
    sink_valid = 0; sink_sop = 0; sink_eop = 0;
    sink_error = 0; sink_real = 0; sink_imag = 0;
    fftpts_in = 0; source_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {sink_ready, source_valid, source_error, source_sop,
         source_eop, source_real, source_imag, fftpts_out}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Stray beat without sop must be dropped.
    put(16'h1234, 16'h5678, 1'b0, 1'b0, 2'b11, 12'd32, 0);
    repeat (3) @(negedge clk);
    chk("stray_no_output", source_valid, 0);

    send_frame(12'd32, 32, 1, 0, 1, 2'b00);
    drain();

    send_frame(12'd2048, 2048, 1, 50, 0, 2'b00);
    drain();

    // Non power of two runs as 2048, no eop given.
    send_frame(12'd48, 2048, 0, 0, 0, 2'b00);
    drain();

    source_ready = 1'b0;
    send_frame(12'd64, 64, 1, 20, 0, 2'b00);
    for (int i = 0; i < 20; i++) begin
      chk("wait_idle", {source_valid, sink_ready}, 0);
      @(negedge clk);
    end
    source_ready = 1'b1;
    t_ref   = $time;
    lat_chk = 1;
    drain();

    send_frame(12'd32, 16, 1, 0, 0, 2'b00);
    drain();
    send_frame(12'd32, 16, 1, 0, 0, 2'b10);
    drain();

    send_frame(12'd128, 128, 1, 30, 0, 2'b00);
    base = pops;
    t = 0;
    while (pops < base + 10 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("readout_start_timeout", 0, 1);
    #2 rst_n = 1'b0;
    #1 chk("mid_reset_outputs",
           {sink_ready, source_valid, source_error, source_sop,
            source_eop, source_real, source_imag, fftpts_out}, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(12'd64, 64, 1, 0, 0, 2'b00);
    drain();

    send_frame(12'd1024, 1024, 1, 10, 0, 2'b00);
    send_frame(12'd128, 128, 1, 10, 0, 2'b00);
    drain();

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
